// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - WORDS*WIDTH-bit add/sub built by time-multiplexing one external WIDTH-bit adder
module multiword_add_seq #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] op_a,
    input  logic [WORDS*WIDTH-1:0] op_b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WIDTH-1:0] result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic [WIDTH-1:0]       adder_a,
    output logic [WIDTH-1:0]       adder_b,
    output logic                   adder_cin,
    input  logic [WIDTH-1:0]       adder_s,
    input  logic                   adder_cout
);

    localparam int IW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int MSB = WORDS*WIDTH-1;
    localparam logic [IW-1:0] LAST = IW'(WORDS-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_next;
    logic [IW-1:0]          idx;
    logic                   carry;
    logic [WORDS*WIDTH-1:0] a_reg, b_reg;
    logic                   sub_reg;
    logic                   a_msb, b_eff_msb;

    assign a_msb     = a_reg[MSB];
    assign b_eff_msb = b_reg[MSB] ^ sub_reg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        adder_a    = '0;
        adder_b    = '0;
        adder_cin  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                adder_a   = a_reg[int'(idx)*WIDTH +: WIDTH];
                adder_b   = b_reg[int'(idx)*WIDTH +: WIDTH] ^ {WIDTH{sub_reg}};
                adder_cin = carry;
                if (idx == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        sub_reg <= sub;
                        idx     <= '0;
                        carry   <= sub;
                    end
                end
                RUN: begin
                    result[int'(idx)*WIDTH +: WIDTH] <= adder_s;
                    carry <= adder_cout;
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        // Final word: its sum MSB is the result sign bit.
                        carry_out <= adder_cout;
                        overflow  <= (a_msb == b_eff_msb) && (adder_s[WIDTH-1] != a_msb);
                        idx       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - directed-vector bench for multiword_add_seq with an 8-bit adder attached
module tb_multiword_add_seq;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int N     = WIDTH*WORDS;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, sub, out_valid, out_ready;
    logic [N-1:0] op_a, op_b, result;
    logic         carry_out, overflow;
    logic [WIDTH-1:0] adder_a, adder_b, adder_s;
    logic         adder_cin, adder_cout;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] b_log   [0:WORDS-1];
    logic             cin_log [0:WORDS-1];
    logic             ready_seen;

    always #5 clk = ~clk;

    assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {{WIDTH{1'b0}}, adder_cin};

    multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .carry_out(carry_out),
        .overflow(overflow), .adder_a(adder_a), .adder_b(adder_b),
        .adder_cin(adder_cin), .adder_s(adder_s), .adder_cout(adder_cout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits for DONE; returns cycles from accept to out_valid.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, output int lat);
        chk("in_ready_before_req", in_ready, 1'b1);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            if (lat < WORDS) begin
                b_log[lat]   = adder_b;
                cin_log[lat] = adder_cin;
            end
            ready_seen = ready_seen | in_ready;
            step();
            lat++;
        end
    endtask

    int lat;
    logic [N-1:0] held;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
        op_a = '0; op_b = '0;
        step(); step();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_adder_a", adder_a, 8'h0);

        // 1: carry into next word, latency, in_ready low during RUN
        do_op(32'h000000FF, 32'h00000001, 1'b0, lat);
        chk("t1_latency", lat, WORDS);
        chk("t1_result", result, 32'h00000100);
        chk("t1_carry", carry_out, 1'b0);
        chk("t1_ovf", overflow, 1'b0);
        chk("t1_in_ready_run", ready_seen, 1'b0);
        chk("t1_in_ready_done", in_ready, 1'b0);
        step();

        // 2: full ripple wrap
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
        chk("t2_result", result, 32'h00000000);
        chk("t2_carry", carry_out, 1'b1);
        chk("t2_ovf", overflow, 1'b0);
        chk("t2_cin_w0", cin_log[0], 1'b0);
        for (int w = 1; w < WORDS; w++) chk($sformatf("t2_cin_w%0d", w), cin_log[w], 1'b1);
        step();

        // 3: signed overflow, add and subtract
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        chk("t3a_result", result, 32'h80000000);
        chk("t3a_ovf", overflow, 1'b1);
        chk("t3a_carry", carry_out, 1'b0);
        step();
        do_op(32'h80000000, 32'h00000001, 1'b1, lat);
        chk("t3b_result", result, 32'h7FFFFFFF);
        chk("t3b_ovf", overflow, 1'b1);
        chk("t3b_carry", carry_out, 1'b1);
        step();

        // 4: borrow
        do_op(32'h00000005, 32'h00000007, 1'b1, lat);
        chk("t4_result", result, 32'hFFFFFFFE);
        chk("t4_carry", carry_out, 1'b0);
        chk("t4_ovf", overflow, 1'b0);
        chk("t4_cin_w0", cin_log[0], 1'b1);
        chk("t4_b_w0", b_log[0], 8'hF8);
        step();

        // 5: backpressure in DONE while pulsing in_valid
        out_ready = 1'b0;
        do_op(32'h00001000, 32'h00000234, 1'b0, lat);
        held = result;
        chk("t5_result", held, 32'h00001234);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_a = 32'hAAAAAAAA; op_b = 32'h11111111;
            step();
            chk("t5_out_valid_held", out_valid, 1'b1);
            chk("t5_result_held", result, held);
            chk("t5_in_ready_low", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t5_idle_in_ready", in_ready, 1'b1);
        chk("t5_idle_out_valid", out_valid, 1'b0);
        chk("t5_idle_result_kept", result, held);
        do_op(32'h00000010, 32'h00000020, 1'b0, lat);
        chk("t5_next_result", result, 32'h00000030);
        step();

        // 6: reset mid-RUN
        op_a = 32'hDEADBEEF; op_b = 32'h01010101; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_result", result, 32'h0);
        chk("t6_in_ready", in_ready, 1'b1);
        do_op(32'h12345678, 32'h11111111, 1'b0, lat);
        chk("t6_result_new", result, 32'h23456789);
        chk("t6_latency", lat, WORDS);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
